// File: rtl/systolic_mm_pkg.sv
// systolic_mm_pkg: shared state encoding and elaboration helpers for the systolic matrix-multiply engine
package systolic_mm_pkg;

   typedef enum logic [2:0] {IDLE, CLEAR, FEED, FLUSH, DRAIN} state_t;

   // Width needed to index v items; never less than one bit.
   function automatic int clog2(input int v);
      int w;
      w = 1;
      while ((1 << w) < v) w++;
      return w;
   endfunction

   // Legal geometry: the accumulator must hold a full product, array at least 1x1.
   function automatic bit params_ok(input int opnd, input int acc, input int rows, input int cols);
      return acc >= 2 * opnd && rows >= 1 && cols >= 1;
   endfunction

endpackage

// File: rtl/systolic_mac_pe.sv
// systolic_mac_pe: one output-stationary MAC cell forwarding A right and B down
module systolic_mac_pe
   import systolic_mm_pkg::*;
#(
   parameter int OPND_BWIDTH = 8,
   parameter int ACC_BWIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall,
   input  logic                   clear,
   input  logic                   signed_mode,
   input  logic [OPND_BWIDTH-1:0] a,
   input  logic                   a_vld,
   input  logic [OPND_BWIDTH-1:0] b,
   input  logic                   b_vld,
   output logic [OPND_BWIDTH-1:0] a_fwd,
   output logic                   a_fwd_vld,
   output logic [OPND_BWIDTH-1:0] b_fwd,
   output logic                   b_fwd_vld,
   output logic [ACC_BWIDTH-1:0]  acc
);

   localparam int XW = ACC_BWIDTH - OPND_BWIDTH;

   logic [ACC_BWIDTH-1:0] a_ext, b_ext, prod;

   // Extending both operands to full width first makes the wrapped product correct in either mode.
   assign a_ext = {{XW{signed_mode & a[OPND_BWIDTH-1]}}, a};
   assign b_ext = {{XW{signed_mode & b[OPND_BWIDTH-1]}}, b};
   assign prod  = a_ext * b_ext;

   // Forward operands one hop and accumulate only when both operands are real beats.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         a_fwd     <= '0;
         a_fwd_vld <= 1'b0;
         b_fwd     <= '0;
         b_fwd_vld <= 1'b0;
         acc       <= '0;
      end else if (!stall) begin
         a_fwd     <= clear ? '0 : a;
         a_fwd_vld <= clear ? 1'b0 : a_vld;
         b_fwd     <= clear ? '0 : b;
         b_fwd_vld <= clear ? 1'b0 : b_vld;
         acc       <= clear ? '0 : (a_vld && b_vld) ? acc + prod : acc;
      end

endmodule

// File: rtl/systolic_mm_engine.sv
// systolic_mm_engine: output-stationary systolic matmul with input skew, run-time K, start/busy/done and row-serial drain
module systolic_mm_engine
   import systolic_mm_pkg::*;
#(
   parameter int OPND_BWIDTH = 8,
   parameter int ACC_BWIDTH  = 32,
   parameter int NUM_ROWS    = 4,
   parameter int NUM_COLS    = 4,
   parameter int KLEN_BWIDTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           stall,
   input  logic                           start,
   input  logic [KLEN_BWIDTH-1:0]         k_len,
   input  logic                           signed_mode,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [NUM_ROWS*OPND_BWIDTH-1:0] opnd1_data,
   input  logic [NUM_COLS*OPND_BWIDTH-1:0] opnd2_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [clog2(NUM_ROWS)-1:0]     out_row,
   output logic [NUM_COLS*ACC_BWIDTH-1:0] out_data,
   output logic                           busy,
   output logic                           done
);

   localparam int W  = OPND_BWIDTH;
   localparam int RW = clog2(NUM_ROWS);
   localparam int FW = clog2(NUM_ROWS + NUM_COLS);

   if (!params_ok(OPND_BWIDTH, ACC_BWIDTH, NUM_ROWS, NUM_COLS)) begin : g_bad_params
      $error("systolic_mm_engine: ACC_BWIDTH must be >= 2*OPND_BWIDTH and the array at least 1x1");
   end

   state_t                 state, state_nxt;
   logic [KLEN_BWIDTH-1:0] k_reg, beat_cnt;
   logic                   sgn_reg;
   logic [FW-1:0]          flush_cnt;
   logic [RW-1:0]          row_idx;
   logic                   accept, clear, last_row_hs;

   logic [W-1:0]          a_h     [NUM_ROWS][NUM_COLS+1];
   logic                  a_h_vld [NUM_ROWS][NUM_COLS+1];
   logic [W-1:0]          b_v     [NUM_ROWS+1][NUM_COLS];
   logic                  b_v_vld [NUM_ROWS+1][NUM_COLS];
   logic [ACC_BWIDTH-1:0] acc     [NUM_ROWS][NUM_COLS];

   assign in_ready    = state == FEED && beat_cnt != k_reg && !stall;
   assign accept      = in_valid & in_ready;
   assign clear       = state == CLEAR;
   assign out_valid   = state == DRAIN;
   assign out_row     = out_valid ? row_idx : '0;
   assign busy        = state != IDLE;
   assign last_row_hs = out_valid && out_ready && !stall && row_idx == RW'(NUM_ROWS - 1);

   // Row r of A enters the array r cycles late; unaccepted cycles inject zero bubbles.
   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_a_skew
      logic [W-1:0] inj;
      assign inj = accept ? opnd1_data[r*W +: W] : '0;
      if (r == 0) begin : g_pass
         assign a_h[r][0]     = inj;
         assign a_h_vld[r][0] = accept;
      end else begin : g_dly
         logic [r*W-1:0] d;
         logic [r-1:0]   v;
         // r-deep shift of operand and valid, cleared at job start
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               d <= '0;
               v <= '0;
            end else if (!stall) begin
               d <= clear ? '0 : (r*W)'({d, inj});
               v <= clear ? '0 : r'({v, accept});
            end
         assign a_h[r][0]     = d[r*W-1 -: W];
         assign a_h_vld[r][0] = v[r-1];
      end
   end

   // Column c of B enters the array c cycles late, mirroring the A skew.
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_b_skew
      logic [W-1:0] inj;
      assign inj = accept ? opnd2_data[c*W +: W] : '0;
      if (c == 0) begin : g_pass
         assign b_v[0][c]     = inj;
         assign b_v_vld[0][c] = accept;
      end else begin : g_dly
         logic [c*W-1:0] d;
         logic [c-1:0]   v;
         // c-deep shift of operand and valid, cleared at job start
         always_ff @(posedge clk or posedge rst)
            if (rst) begin
               d <= '0;
               v <= '0;
            end else if (!stall) begin
               d <= clear ? '0 : (c*W)'({d, inj});
               v <= clear ? '0 : c'({v, accept});
            end
         assign b_v[0][c]     = d[c*W-1 -: W];
         assign b_v_vld[0][c] = v[c-1];
      end
   end

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
         systolic_mac_pe #(
            .OPND_BWIDTH (OPND_BWIDTH),
            .ACC_BWIDTH  (ACC_BWIDTH)
         ) u_pe (
            .clk         (clk),
            .rst         (rst),
            .stall       (stall),
            .clear       (clear),
            .signed_mode (sgn_reg),
            .a           (a_h[r][c]),
            .a_vld       (a_h_vld[r][c]),
            .b           (b_v[r][c]),
            .b_vld       (b_v_vld[r][c]),
            .a_fwd       (a_h[r][c+1]),
            .a_fwd_vld   (a_h_vld[r][c+1]),
            .b_fwd       (b_v[r+1][c]),
            .b_fwd_vld   (b_v_vld[r+1][c]),
            .acc         (acc[r][c])
         );
      end
   end

   for (genvar c = 0; c < NUM_COLS; c++) begin : g_out
      assign out_data[c*ACC_BWIDTH +: ACC_BWIDTH] = out_valid ? acc[row_idx][c] : '0;
   end

   // Next-state: FLUSH lasts long enough for the last beat to reach the far corner PE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = CLEAR;
         CLEAR:   state_nxt = k_reg == '0 ? FLUSH : FEED;
         FEED:    if (accept && beat_cnt + KLEN_BWIDTH'(1) == k_reg) state_nxt = FLUSH;
         FLUSH:   if (flush_cnt == FW'(NUM_ROWS + NUM_COLS - 2)) state_nxt = DRAIN;
         DRAIN:   if (out_ready && row_idx == RW'(NUM_ROWS - 1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, job parameters and counters; everything holds while stalled.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         k_reg     <= '0;
         sgn_reg   <= 1'b0;
         beat_cnt  <= '0;
         flush_cnt <= '0;
         row_idx   <= '0;
      end else if (!stall) begin
         state     <= state_nxt;
         k_reg     <= (state == IDLE && start) ? k_len : k_reg;
         sgn_reg   <= (state == IDLE && start) ? signed_mode : sgn_reg;
         beat_cnt  <= clear ? '0 : beat_cnt + KLEN_BWIDTH'(accept);
         flush_cnt <= state == FLUSH ? flush_cnt + FW'(1) : '0;
         row_idx   <= state == DRAIN ? row_idx + RW'(out_ready) : '0;
      end

   // Completion pulse lasts exactly one cycle even if a stall follows the final handshake.
   always_ff @(posedge clk or posedge rst)
      if (rst) done <= 1'b0;
      else done <= last_row_hs;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb_systolic_mm_engine: randomized and directed checks of the systolic engine against a plain matrix-product model
module tb_systolic_mm_engine;

   localparam int M = 4, N = 4, W = 8, AW = 32, KB = 8, MAXK = 16;

   logic           clk = 1'b0;
   logic           rst, stall, start, signed_mode, in_valid, in_ready;
   logic           out_valid, out_ready, busy, done;
   logic [KB-1:0]  k_len;
   logic [M*W-1:0] opnd1_data;
   logic [N*W-1:0] opnd2_data;
   logic [1:0]     out_row;
   logic [N*AW-1:0] out_data;

   int checks = 0, errors = 0;

   logic [W-1:0]  am  [M][MAXK];
   logic [W-1:0]  bm  [MAXK][N];
   logic [AW-1:0] got [M][N];
   int order[$];
   int first_valid, done_cyc, last_hs_cyc, unstable, held_cnt;

   systolic_mm_engine dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .start       (start),
      .k_len       (k_len),
      .signed_mode (signed_mode),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opnd1_data  (opnd1_data),
      .opnd2_data  (opnd2_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_row     (out_row),
      .out_data    (out_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // C[r][c] = sum_i A[r][i]*B[i][c], operands read as signed or unsigned, wrapped to 32 bits
   function automatic logic [AW-1:0] ref_c(input int r, input int c, input int k, input bit sgn);
      logic [AW-1:0] s;
      int x, y;
      s = '0;
      for (int i = 0; i < k; i++) begin
         x = sgn ? int'($signed(am[r][i])) : int'(am[r][i]);
         y = sgn ? int'($signed(bm[i][c])) : int'(bm[i][c]);
         s = s + AW'(x * y);
      end
      return s;
   endfunction

   task automatic load_identity();
      for (int k = 0; k < 4; k++)
         for (int r = 0; r < M; r++) am[r][k] = (r == k) ? 8'd1 : 8'd0;
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < N; c++) bm[k][c] = W'(4 * k + c + 1);
   endtask

   task automatic load_random(input int k);
      for (int i = 0; i < k; i++) begin
         for (int r = 0; r < M; r++) am[r][i] = W'($urandom);
         for (int c = 0; c < N; c++) bm[i][c] = W'($urandom);
      end
   endtask

   // Drives one job cycle by cycle (cycle 0 = START sampled) and records drained rows and timing.
   task automatic run_job(input int k, input bit sgn, input int iv_mode, input int or_mode, input int hold_row,
                          input int s1, input int s1n, input int s2, input int s2n, input int busy_start, input int rst_row);
      int bi;
      bit prev_held, hs;
      logic [1:0] prev_row;
      logic [N*AW-1:0] prev_data;
      bi = 0;
      prev_held = 0;
      prev_row = '0;
      prev_data = '0;
      order.delete();
      first_valid = -1;
      done_cyc = -1;
      last_hs_cyc = -1;
      unstable = 0;
      held_cnt = 0;
      foreach (got[r, c]) got[r][c] = 'x;
      @(posedge clk);
      #1;
      start = 1'b1;
      k_len = KB'(k);
      signed_mode = sgn;
      stall = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         @(posedge clk);
         #1;
         start = (n == busy_start);
         if (n == busy_start) k_len = KB'(5);
         if (prev_held && (out_valid !== 1'b1 || out_row !== prev_row || out_data !== prev_data)) unstable++;
         if (out_valid === 1'b1 && first_valid < 0) first_valid = n;
         if (done === 1'b1) begin
            done_cyc = n;
            break;
         end
         if (rst_row >= 0 && out_valid === 1'b1 && int'(out_row) == rst_row) begin
            rst = 1'b1;
            break;
         end
         stall = (n >= s1 && n < s1 + s1n) || (n >= s2 && n < s2 + s2n);
         in_valid = iv_mode == 0 ? 1'b1 : iv_mode == 1 ? n[0] : 1'($urandom);
         for (int r = 0; r < M; r++) opnd1_data[r*W +: W] = (in_valid && bi < k) ? am[r][bi] : W'($urandom);
         for (int c = 0; c < N; c++) opnd2_data[c*W +: W] = (in_valid && bi < k) ? bm[bi][c] : W'($urandom);
         if (or_mode == 1) out_ready = 1'($urandom);
         else begin
            out_ready = !(out_valid && int'(out_row) == hold_row && held_cnt < 3);
            if (!out_ready) held_cnt++;
         end
         #1;
         if (in_valid && in_ready) bi++;
         hs = out_valid && out_ready && !stall;
         if (hs) begin
            for (int c = 0; c < N; c++) got[out_row][c] = out_data[c*AW +: AW];
            order.push_back(int'(out_row));
            last_hs_cyc = n;
         end
         prev_held = out_valid && !hs;
         prev_row = out_row;
         prev_data = out_data;
         if (n == 400) begin
            checks++;
            errors++;
            $display("FAIL timeout: no DONE within 400 cycles, rows drained %0d required %0d", order.size(), M);
         end
      end
      start = 1'b0;
      in_valid = 1'b0;
      stall = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      checks++; if (out_row !== 2'd0) begin errors++; $display("FAIL reset_out_row got %0d want 0", out_row); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
   endtask

   task automatic test_identity(input string tag);
      load_identity();
      run_job(4, 1'b0, 0, 0, -1, 0, 0, 0, 0, -1, -1);
      checks++; if (first_valid != 13) begin errors++; $display("FAIL %s_first_valid got %0d want 13", tag, first_valid); end
      checks++; if (done_cyc != 17 || last_hs_cyc != 16) begin errors++; $display("FAIL %s_done_cycle got %0d/%0d want 17/16", tag, done_cyc, last_hs_cyc); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got %b want 0", tag, busy); end
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            checks++;
            if (got[r][c] !== AW'(4 * r + c + 1)) begin errors++; $display("FAIL %s_C[%0d][%0d] got %h want %h", tag, r, c, got[r][c], 4 * r + c + 1); end
         end
      @(posedge clk);
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width got %b want 0", tag, done); end
   endtask

   task automatic test_sign();
      for (int r = 0; r < M; r++) am[r][0] = 8'hFF;
      for (int c = 0; c < N; c++) bm[0][c] = 8'h80;
      run_job(1, 1'b1, 0, 0, -1, 0, 0, 0, 0, -1, -1);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            checks++;
            if (got[r][c] !== 32'h0000_0080) begin errors++; $display("FAIL signed_C[%0d][%0d] got %h want 00000080", r, c, got[r][c]); end
         end
      run_job(1, 1'b0, 0, 0, -1, 0, 0, 0, 0, -1, -1);
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            checks++;
            if (got[r][c] !== 32'h0000_7F80) begin errors++; $display("FAIL unsigned_C[%0d][%0d] got %h want 00007f80", r, c, got[r][c]); end
         end
   endtask

   task automatic test_backpressure();
      load_identity();
      run_job(4, 1'b0, 1, 0, 2, 0, 0, 0, 0, -1, -1);
      checks++; if (held_cnt != 3) begin errors++; $display("FAIL bp_hold_cycles got %0d want 3", held_cnt); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL bp_held_row_stable got %0d changes want 0", unstable); end
      checks++; if (order.size() != M) begin errors++; $display("FAIL bp_row_count got %0d want %0d", order.size(), M); end
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            checks++;
            if (got[r][c] !== ref_c(r, c, 4, 1'b0)) begin errors++; $display("FAIL bp_C[%0d][%0d] got %h want %h", r, c, got[r][c], ref_c(r, c, 4, 1'b0)); end
         end
   endtask

   task automatic test_stall();
      load_identity();
      run_job(4, 1'b0, 0, 0, -1, 3, 5, 19, 2, -1, -1);
      checks++; if (first_valid != 18) begin errors++; $display("FAIL stall_first_valid got %0d want 18", first_valid); end
      checks++; if (done_cyc != 24) begin errors++; $display("FAIL stall_done_cycle got %0d want 24", done_cyc); end
      checks++; if (unstable != 0) begin errors++; $display("FAIL stall_drain_stable got %0d changes want 0", unstable); end
      checks++; if (order.size() != M) begin errors++; $display("FAIL stall_row_count got %0d want %0d", order.size(), M); end
      for (int i = 0; i < order.size(); i++) begin
         checks++;
         if (order[i] != i) begin errors++; $display("FAIL stall_row_order[%0d] got %0d want %0d", i, order[i], i); end
      end
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            checks++;
            if (got[r][c] !== AW'(4 * r + c + 1)) begin errors++; $display("FAIL stall_C[%0d][%0d] got %h want %h", r, c, got[r][c], 4 * r + c + 1); end
         end
   endtask

   task automatic test_klen_zero();
      run_job(0, 1'b0, 0, 0, -1, 0, 0, 0, 0, 3, -1);
      checks++; if (first_valid != 9) begin errors++; $display("FAIL k0_first_valid got %0d want 9", first_valid); end
      checks++; if (order.size() != M) begin errors++; $display("FAIL k0_row_count got %0d want %0d", order.size(), M); end
      for (int r = 0; r < M; r++)
         for (int c = 0; c < N; c++) begin
            checks++;
            if (got[r][c] !== 32'd0) begin errors++; $display("FAIL k0_C[%0d][%0d] got %h want 0", r, c, got[r][c]); end
         end
      repeat (4) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL k0_idle_after got busy %b want 0", busy); end
   endtask

   task automatic test_reset_mid_drain();
      load_identity();
      run_job(4, 1'b0, 0, 0, -1, 0, 0, 0, 0, -1, 1);
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_out_valid got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_drain_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_drain_done got %b want 0", done); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_drain_out_data got %h want 0", out_data); end
      rst = 1'b0;
      test_identity("after_rst");
   endtask

   task automatic test_random();
      int k;
      bit sgn;
      for (int j = 0; j < 4; j++) begin
         k = $urandom_range(1, 12);
         sgn = 1'($urandom);
         load_random(k);
         run_job(k, sgn, 2, 1, -1, 0, 0, 0, 0, -1, -1);
         checks++; if (unstable != 0) begin errors++; $display("FAIL rand%0d_stable got %0d changes want 0", j, unstable); end
         checks++; if (order.size() != M) begin errors++; $display("FAIL rand%0d_row_count got %0d want %0d", j, order.size(), M); end
         for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) begin
               checks++;
               if (got[r][c] !== ref_c(r, c, k, sgn)) begin errors++; $display("FAIL rand%0d_C[%0d][%0d] k=%0d s=%0d got %h want %h", j, r, c, k, sgn, got[r][c], ref_c(r, c, k, sgn)); end
            end
      end
   endtask

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      start = 1'b0;
      k_len = '0;
      signed_mode = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      opnd1_data = '0;
      opnd2_data = '0;
      test_reset();
      test_identity("ident");
      test_sign();
      test_backpressure();
      test_stall();
      test_klen_zero();
      test_reset_mid_drain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
